// File: rtl/xfer_byte_counter.sv
// xfer_byte_counter: remaining-byte counter for beat-wide packet transfers with done pulse and sticky overrun
module xfer_byte_counter #(
    parameter int BITS       = 6,
    parameter int BEAT_BYTES = 4,
    parameter int CW         = $clog2(BEAT_BYTES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [BITS-1:0] packet_length,
    input  logic            consume,
    input  logic [CW-1:0]   consume_bytes,
    input  logic            abort,
    output logic [BITS:0]   remaining,
    output logic            zero,
    output logic            one,
    output logic            last_beat,
    output logic            busy,
    output logic            done,
    output logic            overrun
);
    localparam int W  = BITS + 1;
    localparam int XW = (CW > W) ? CW : W;

    typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  rem_nx;
    logic          done_nx, ovr_nx;
    logic [CW-1:0] b_sat;
    logic [XW-1:0] b_x, rem_x;
    logic [W-1:0]  load_val;

    assign b_sat    = (32'(consume_bytes) > BEAT_BYTES) ? CW'(BEAT_BYTES) : consume_bytes;
    assign b_x      = XW'(b_sat);
    assign rem_x    = XW'(remaining);
    assign load_val = (packet_length == '0) ? W'(1) << BITS : {1'b0, packet_length};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= rem_nx;
            done      <= done_nx;
            overrun   <= ovr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rem_nx   = remaining;
        done_nx  = 1'b0;
        ovr_nx   = overrun;
        if (abort) begin
            state_nx = IDLE;
            rem_nx   = '0;
            ovr_nx   = 1'b0;
        end else if (load) begin
            state_nx = ACTIVE;
            rem_nx   = load_val;
            ovr_nx   = 1'b0;
        end else if (consume && b_sat != '0) begin
            if (state == ACTIVE) begin
                if (b_x < rem_x) begin
                    rem_nx = W'(rem_x - b_x);
                end else if (b_x == rem_x) begin
                    rem_nx   = '0;
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    rem_nx   = '0;
                    state_nx = ERROR;
                    ovr_nx   = 1'b1;
                end
            end else if (state == IDLE) begin
                state_nx = ERROR;
                ovr_nx   = 1'b1;
            end
        end
    end

    always_comb begin
        zero      = remaining == '0;
        one       = remaining == W'(1);
        last_beat = remaining != '0 && 32'(remaining) <= BEAT_BYTES;
        busy      = state == ACTIVE;
    end
endmodule

// File: tb/tb_xfer_byte_counter.sv
// tb_xfer_byte_counter: directed vectors with hand-computed expectations for xfer_byte_counter
module tb_xfer_byte_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [5:0] packet_length = '0;
    logic       consume = 1'b0;
    logic [2:0] consume_bytes = '0;
    logic       abort = 1'b0;
    logic [6:0] remaining;
    logic       zero, one, last_beat, busy, done, overrun;
    int         vectors = 0;
    int         miscompares = 0;
    int         one_seen;

    xfer_byte_counter #(.BITS(6), .BEAT_BYTES(4)) dut (
        .clk(clk), .rst(rst), .load(load), .packet_length(packet_length),
        .consume(consume), .consume_bytes(consume_bytes), .abort(abort),
        .remaining(remaining), .zero(zero), .one(one), .last_beat(last_beat),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic [5:0] pl, input logic c, input logic [2:0] b, input logic a);
        load = l;
        packet_length = pl;
        consume = c;
        consume_bytes = b;
        abort = a;
    endtask

    initial begin
        #2 rst = 1'b1;
        #2;
        check("rst_rem", 32'(remaining), 0);
        check("rst_zero", 32'(zero), 1);
        check("rst_one", 32'(one), 0);
        check("rst_last", 32'(last_beat), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ovr", 32'(overrun), 0);
        cycle();
        rst = 1'b0;
        cycle();

        drive(1, 10, 0, 0, 0); cycle();
        check("basic_rem10", 32'(remaining), 10);
        check("basic_busy", 32'(busy), 1);
        check("basic_last10", 32'(last_beat), 0);
        drive(0, 0, 1, 4, 0); cycle();
        check("basic_rem6", 32'(remaining), 6);
        check("basic_last6", 32'(last_beat), 0);
        check("basic_done6", 32'(done), 0);
        cycle();
        check("basic_rem2", 32'(remaining), 2);
        check("basic_last2", 32'(last_beat), 1);
        drive(0, 0, 1, 2, 0); cycle();
        check("basic_rem0", 32'(remaining), 0);
        check("basic_done", 32'(done), 1);
        check("basic_busy0", 32'(busy), 0);
        check("basic_last0", 32'(last_beat), 0);
        drive(0, 0, 0, 0, 0); cycle();
        check("basic_done_drop", 32'(done), 0);

        drive(1, 0, 0, 0, 0); cycle();
        check("len0_rem64", 32'(remaining), 64);
        drive(0, 0, 1, 4, 0);
        one_seen = 0;
        for (int i = 1; i <= 16; i++) begin
            cycle();
            if (one) one_seen++;
            if (i == 15) begin
                check("len0_rem4", 32'(remaining), 4);
                check("len0_last4", 32'(last_beat), 1);
                check("len0_done15", 32'(done), 0);
            end
        end
        check("len0_done16", 32'(done), 1);
        check("len0_one_never", 32'(one_seen), 0);
        drive(0, 0, 0, 0, 0); cycle();

        drive(1, 3, 0, 0, 0); cycle();
        drive(0, 0, 1, 4, 0); cycle();
        check("ovr_rem", 32'(remaining), 0);
        check("ovr_flag", 32'(overrun), 1);
        check("ovr_busy", 32'(busy), 0);
        check("ovr_done", 32'(done), 0);
        cycle();
        check("ovr_ignore_rem", 32'(remaining), 0);
        check("ovr_sticky", 32'(overrun), 1);
        drive(1, 5, 1, 4, 0); cycle();
        check("coll_load_rem5", 32'(remaining), 5);
        check("coll_ovr_clr", 32'(overrun), 0);
        check("coll_busy", 32'(busy), 1);
        drive(0, 0, 1, 4, 0); cycle();
        check("coll_rem1", 32'(remaining), 1);
        check("coll_one", 32'(one), 1);
        check("coll_last", 32'(last_beat), 1);
        drive(0, 0, 1, 1, 0); cycle();
        check("b2b_done", 32'(done), 1);
        drive(1, 2, 0, 0, 0); cycle();
        check("b2b_rem2", 32'(remaining), 2);
        check("b2b_done_drop", 32'(done), 0);
        check("b2b_busy", 32'(busy), 1);

        drive(1, 9, 0, 0, 1); cycle();
        check("abort_rem", 32'(remaining), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);

        drive(0, 0, 1, 0, 0); cycle();
        check("idle_b0_rem", 32'(remaining), 0);
        check("idle_b0_ovr", 32'(overrun), 0);
        drive(0, 0, 1, 1, 0); cycle();
        check("idle_b1_ovr", 32'(overrun), 1);
        check("idle_b1_busy", 32'(busy), 0);

        drive(1, 10, 0, 0, 0); cycle();
        drive(0, 0, 1, 7, 0); cycle();
        check("sat_rem6", 32'(remaining), 6);
        check("sat_ovr", 32'(overrun), 0);

        drive(1, 20, 0, 0, 0); cycle();
        drive(0, 0, 1, 4, 0); cycle();
        check("areset_pre", 32'(remaining), 16);
        drive(0, 0, 0, 0, 0);
        #3 rst = 1'b1;
        #1;
        check("areset_rem", 32'(remaining), 0);
        check("areset_zero", 32'(zero), 1);
        check("areset_busy", 32'(busy), 0);
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("areset_no_done", 32'(done), 0);
        end
        check("areset_rem_after", 32'(remaining), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
